// File: rtl/jtframe_ba0_arb.sv
// jtframe_ba0_arb: round-robin arbiter sharing SDRAM bank 0 among four requesters
module jtframe_ba0_arb #(
   parameter int SDRAMW = 23,
   parameter int TOUT   = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*SDRAMW-1:0] req_addr,
   input  logic [3:0]          req_rd,
   input  logic [3:0]          req_wr,
   input  logic [63:0]         req_din,
   input  logic [7:0]          req_din_m,
   output logic [3:0]          req_ok,
   output logic [3:0]          req_err,
   output logic [15:0]         req_dout,
   output logic [SDRAMW-1:0]   ba0_addr,
   output logic                ba0_rd,
   output logic                ba0_wr,
   output logic [15:0]         ba0_din,
   output logic [1:0]          ba0_din_m,
   input  logic                ba0_ack,
   input  logic                ba0_rdy,
   input  logic [15:0]         sdram_dout,
   output logic                busy
);
   localparam int WW = $clog2(TOUT + 1);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0]        state_q, state_d, ptr_q, ptr_d, gnt_q, gnt_d, sel;
   logic [WW-1:0]     wdog_q, wdog_d;
   logic              is_wr_q, is_wr_d, excl_q, rd_q, rd_d, wr_q, wr_d, found, fin, tout;
   logic [3:0]        pend, ok_q, ok_d, err_q, err_d;
   logic [15:0]       dout_q, dout_d, din_q, din_d;
   logic [1:0]        m_q, m_d;
   logic [SDRAMW-1:0] addr_q, addr_d;
   assign req_ok    = ok_q;
   assign req_err   = err_q;
   assign req_dout  = dout_q;
   assign ba0_addr  = addr_q;
   assign ba0_rd    = rd_q;
   assign ba0_wr    = wr_q;
   assign ba0_din   = din_q;
   assign ba0_din_m = m_q;
   assign busy      = state_q != IDLE;
   // first pending requester from the pointer; the one just served sits out the first IDLE cycle
   always_comb begin
      pend  = (req_rd | req_wr) & ~(excl_q ? 4'b0001 << gnt_q : 4'b0000);
      sel   = ptr_q;
      found = 1'b0;
      for (int i = 3; i >= 0; i--)
         if (pend[ptr_q + 2'(i)]) begin
            sel   = ptr_q + 2'(i);
            found = 1'b1;
         end
   end
   // transfer sequencing, watchdog and completion
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      wdog_d  = wdog_q;
      is_wr_d = is_wr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      din_d   = din_q;
      m_d     = m_q;
      dout_d  = dout_q;
      ok_d    = 4'b0000;
      err_d   = 4'b0000;
      fin     = ba0_rdy & (ba0_ack | state_q == WAIT);
      tout    = wdog_q == WW'(TOUT - 1);
      case (state_q)
         IDLE: if (found) begin
            state_d = REQ;
            gnt_d   = sel;
            wdog_d  = '0;
            addr_d  = req_addr[int'(sel)*SDRAMW +: SDRAMW];
            din_d   = req_din[int'(sel)*16 +: 16];
            m_d     = req_din_m[int'(sel)*2 +: 2];
            wr_d    = req_wr[sel];
            rd_d    = req_rd[sel] & ~req_wr[sel];
            is_wr_d = req_wr[sel];
         end
         REQ, WAIT: if (fin | tout) begin
            state_d = DONE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ptr_d   = gnt_q + 2'd1;
            dout_d  = fin & ~is_wr_q ? sdram_dout : dout_q;
            ok_d    = fin ? 4'b0001 << gnt_q : 4'b0000;
            err_d   = fin ? 4'b0000 : 4'b0001 << gnt_q;
         end else begin
            wdog_d = wdog_q + 1'b1;
            if (state_q == REQ && ba0_ack) begin
               state_d = WAIT;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         DONE: state_d = IDLE;
      endcase
   end
   // state registers; reset abandons any transfer in flight
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         wdog_q  <= '0;
         is_wr_q <= 1'b0;
         excl_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         m_q     <= '0;
         dout_q  <= '0;
         ok_q    <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wdog_q  <= wdog_d;
         is_wr_q <= is_wr_d;
         excl_q  <= state_q == DONE;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         m_q     <= m_d;
         dout_q  <= dout_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
endmodule
